// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// digit width, the add-3 threshold, FSM states and a sizing helper.
package bcd_pkg;

    localparam int BCD_DIGIT_W = 4;

    localparam logic [BCD_DIGIT_W-1:0] ADD3_THRESHOLD = 4'd5;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Number of decimal digits needed to show the largest unsigned value
    // of the given bit width (2^width - 1).
    function automatic int digits_needed(input int width);
        longint unsigned max_val;
        longint unsigned rest;
        int              n;
        max_val = (64'd1 << width) - 64'd1;
        n       = 1;
        rest    = max_val / 10;
        while (rest != 0) begin
            n    = n + 1;
            rest = rest / 10;
        end
        return n;
    endfunction

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Handshake bundle between the datapath controller (master) and the
// binary-to-BCD converter (slave).
interface bin_to_bcd_seq_if #(
    parameter int IN_WIDTH = 8,
    parameter int DIGITS   = 3
);
    logic                start;
    logic [IN_WIDTH-1:0] bin;
    logic                busy;
    logic                done;
    logic [4*DIGITS-1:0] bcd;

    modport master (
        output start,
        output bin,
        input  busy,
        input  done,
        input  bcd
    );

    modport slave (
        input  start,
        input  bin,
        output busy,
        output done,
        output bcd
    );
endinterface

// File: rtl/bcd_add3_digit.sv
// Double-dabble correction for one BCD digit: values of 5 and above get +3
// so that the following left shift carries correctly into the next digit.
module bcd_add3_digit
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit,
    output logic [BCD_DIGIT_W-1:0] fixed
);

    // Conditional add-3; the result wraps within the digit, which never
    // matters because corrected digits only ever come from values 0..9.
    always_comb begin
        fixed = digit;
        if (digit >= ADD3_THRESHOLD) begin
            fixed = digit + 4'd3;
        end
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Iterative shift-add-3 converter: one input bit per clock, producing packed
// BCD digits for the downstream 7-segment decoders.
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int IN_WIDTH = 8,
    parameter int DIGITS   = 3
) (
    input  logic            clk,
    input  logic            rst,
    bin_to_bcd_seq_if.slave bus
);

    localparam int SCR_W = BCD_DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(IN_WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(IN_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

    if (DIGITS < digits_needed(IN_WIDTH)) begin : g_width_check
        $error("bin_to_bcd_seq: DIGITS too small for IN_WIDTH");
    end

    state_t              state;
    logic [IN_WIDTH-1:0] shift_reg;
    logic [SCR_W-1:0]    scratch;
    logic [CNT_W-1:0]    count;
    logic                busy;
    logic                done;
    logic [SCR_W-1:0]    bcd;

    logic [SCR_W-1:0]          corrected;
    logic [SCR_W+IN_WIDTH-1:0] shifted;
    logic [SCR_W-1:0]          scratch_next;
    logic [IN_WIDTH-1:0]       shift_next;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_add3_digit u_add3 (
            .digit (scratch[BCD_DIGIT_W*i +: BCD_DIGIT_W]),
            .fixed (corrected[BCD_DIGIT_W*i +: BCD_DIGIT_W])
        );
    end

    // One double-dabble step: shift the corrected digits and the remaining
    // binary bits left together so the binary MSB lands in digit 0 bit 0.
    always_comb begin
        shifted      = {corrected, shift_reg} << 1;
        scratch_next = shifted[SCR_W+IN_WIDTH-1:IN_WIDTH];
        shift_next   = shifted[IN_WIDTH-1:0];
    end

    // Control FSM and datapath registers; the final step publishes the
    // result and returns to IDLE so a new start can be taken immediately.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            bcd       <= '0;
            scratch   <= '0;
            shift_reg <= '0;
            count     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (bus.start) begin
                        shift_reg <= bus.bin;
                        scratch   <= '0;
                        count     <= CNT_INIT;
                        busy      <= 1'b1;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch   <= scratch_next;
                    shift_reg <= shift_next;
                    count     <= count - 1'b1;
                    if (count == CNT_LAST) begin
                        bcd   <= scratch_next;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.busy = busy;
    assign bus.done = done;
    assign bus.bcd  = bcd;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed self-checking bench for bin_to_bcd_seq (IN_WIDTH=8, DIGITS=3).
module tb_bin_to_bcd_seq;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    bin_to_bcd_seq_if #(.IN_WIDTH(8), .DIGITS(3)) bus ();

    bin_to_bcd_seq #(.IN_WIDTH(8), .DIGITS(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Active-low {g,f,e,d,c,b,a} glyph for one decimal digit.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0: seg7 = 7'b1000000;
            4'd1: seg7 = 7'b1111001;
            4'd2: seg7 = 7'b0100100;
            4'd3: seg7 = 7'b0110000;
            4'd4: seg7 = 7'b0011001;
            4'd5: seg7 = 7'b0010010;
            4'd6: seg7 = 7'b0000010;
            4'd7: seg7 = 7'b1111000;
            4'd8: seg7 = 7'b0000000;
            4'd9: seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    // Pulse start for one cycle with the given value; returns just after
    // the accepting edge.
    task automatic applyStimulus(input logic [7:0] value);
        @(negedge clk);
        bus.start = 1'b1;
        bus.bin   = value;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Wait (bounded) for done; lat = edges since the accepting edge.
    task automatic waitDone(output int lat, output int busy_cnt);
        lat      = 0;
        busy_cnt = 0;
        while (bus.done !== 1'b1 && lat < 20) begin
            if (bus.busy === 1'b1) busy_cnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    // Full conversion with latency, busy span, result and pulse width checks.
    task automatic convertAndCheck(input string tag, input logic [7:0] value, input logic [11:0] exp_bcd);
        int lat;
        int busy_cnt;
        applyStimulus(value);
        waitDone(lat, busy_cnt);
        checkOutput({tag, "_latency"}, lat, 8);
        checkOutput({tag, "_busy_cycles"}, busy_cnt, 8);
        checkOutput({tag, "_bcd"}, bus.bcd, exp_bcd);
        checkOutput({tag, "_busy_at_done"}, bus.busy, 0);
        @(negedge clk);
        checkOutput({tag, "_done_one_cycle"}, bus.done, 0);
        checkOutput({tag, "_bcd_hold"}, bus.bcd, exp_bcd);
    endtask

    initial begin
        int lat;
        int busy_cnt;
        int done_cnt;
        logic [11:0] ref_bcd;

        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.bin   = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset_busy", bus.busy, 0);
        checkOutput("reset_done", bus.done, 0);
        checkOutput("reset_bcd", bus.bcd, 0);
        rst = 1'b0;

        convertAndCheck("zero", 8'd0, 12'h000);
        convertAndCheck("v255", 8'd255, 12'h255);
        checkOutput("seg_d2", seg7(bus.bcd[11:8]), 7'b0100100);
        checkOutput("seg_d1", seg7(bus.bcd[7:4]), 7'b0010010);
        checkOutput("seg_d0", seg7(bus.bcd[3:0]), 7'b0010010);
        convertAndCheck("v99", 8'd99, 12'h099);
        convertAndCheck("v100", 8'd100, 12'h100);

        // start held for three cycles, bin changed while busy
        @(negedge clk);
        bus.start = 1'b1;
        bus.bin   = 8'd37;
        @(negedge clk);
        @(negedge clk);
        bus.bin = 8'd200;
        @(negedge clk);
        bus.start = 1'b0;
        done_cnt  = 0;
        for (int i = 0; i < 16; i++) begin
            if (bus.done === 1'b1) begin
                done_cnt++;
                checkOutput("held_bcd", bus.bcd, 12'h037);
            end
            @(negedge clk);
        end
        checkOutput("held_done_count", done_cnt, 1);
        checkOutput("held_idle_after", bus.busy, 0);

        // back-to-back: start issued in the done cycle
        applyStimulus(8'd100);
        waitDone(lat, busy_cnt);
        checkOutput("b2b_first_bcd", bus.bcd, 12'h100);
        bus.start = 1'b1;
        bus.bin   = 8'd128;
        @(negedge clk);
        bus.start = 1'b0;
        checkOutput("b2b_busy", bus.busy, 1);
        checkOutput("b2b_first_stable", bus.bcd, 12'h100);
        waitDone(lat, busy_cnt);
        checkOutput("b2b_latency", lat, 8);
        checkOutput("b2b_second_bcd", bus.bcd, 12'h128);

        // reset in the middle of a conversion
        applyStimulus(8'd255);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort_busy", bus.busy, 0);
        checkOutput("abort_done", bus.done, 0);
        checkOutput("abort_bcd", bus.bcd, 0);
        rst      = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.done === 1'b1) done_cnt++;
            @(negedge clk);
        end
        checkOutput("abort_no_done", done_cnt, 0);
        convertAndCheck("after_abort", 8'd7, 12'h007);

        // reset and start together: start is dropped
        bus.start = 1'b1;
        bus.bin   = 8'd55;
        rst       = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        checkOutput("rst_start_busy", bus.busy, 0);
        checkOutput("rst_start_bcd", bus.bcd, 0);

        // sweep all inputs against a decimal split
        for (int v = 0; v < 256; v++) begin
            ref_bcd = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
            applyStimulus(8'(v));
            waitDone(lat, busy_cnt);
            checkOutput($sformatf("sweep_%0d", v), bus.bcd, ref_bcd);
            checkOutput($sformatf("sweep_digits_%0d", v),
                        (bus.bcd[3:0] <= 9) && (bus.bcd[7:4] <= 9) && (bus.bcd[11:8] <= 9), 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
